// File: rtl/spi_flash_model.sv
// SPI NOR flash responder for system benches: oversamples a mode-0 SPI bus with clk
// and answers READ, FAST_READ, RDID and RDSR from a backdoor-loaded byte array.
module spi_flash_model #(
  parameter int          ADDR_BYTES  = 3,
  parameter int          MEM_AW      = 12,
  parameter int          DUMMY_BYTES = 1,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
  parameter int          CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              flash_CS,
  input  logic              sck_i,
  input  logic              mosi_i,
  output logic              miso_o,
  input  logic              bd_we_i,
  input  logic [MEM_AW-1:0] bd_addr_i,
  input  logic [7:0]        bd_data_i,
  output logic              busy_o,
  output logic [CNT_W-1:0]  cmd_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_ID, S_STATUS, S_IGNORE
  } state_t;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_RDID      = 8'h9F;
  localparam logic [7:0] OP_RDSR      = 8'h05;

  logic [7:0] mem [2**MEM_AW];

  logic [1:0]        cs_sync, sck_sync, mosi_sync;
  logic              cs_prev, sck_prev;
  logic              cs_s, sck_rise, sck_fall, cs_fall, byte_done;
  logic [7:0]        rx_byte;
  logic [MEM_AW-1:0] ptr_shift;

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [2:0]        addr_cnt;
  logic [2:0]        dummy_cnt;
  logic [1:0]        id_idx;
  logic              is_fast;
  logic              recognised;
  logic [6:0]        rx_sh;
  logic [7:0]        tx_sh;
  logic [MEM_AW-1:0] ptr;

  // NOTE: the backdoor array has no reset; its contents must survive rst_i and
  // a reset branch would also stop it mapping onto a plain RAM.
  always_ff @(posedge clk) begin
    if (bd_we_i) mem[bd_addr_i] <= bd_data_i;
  end

  // cs_prev resets low so a CS already held low at reset exit never reads as a fall.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      cs_sync   <= '0;
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_prev   <= 1'b0;
      sck_prev  <= 1'b0;
    end else begin
      // NOTE: every flop uses <= so the chain shifts by exactly one stage per clk.
      cs_sync   <= {cs_sync[0], flash_CS};
      sck_sync  <= {sck_sync[0], sck_i};
      mosi_sync <= {mosi_sync[0], mosi_i};
      cs_prev   <= cs_sync[1];
      sck_prev  <= sck_sync[1];
    end
  end

  // NOTE: every signal in this block is assigned unconditionally, so no latch is inferred.
  always_comb begin
    cs_s      = cs_sync[1];
    sck_rise  = sck_sync[1] & ~sck_prev;
    sck_fall  = ~sck_sync[1] & sck_prev;
    cs_fall   = cs_prev & ~cs_sync[1];
    rx_byte   = {rx_sh, mosi_sync[1]};
    byte_done = sck_rise && (bit_cnt == 3'd7);
    ptr_shift = MEM_AW'({ptr, rx_byte});
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state      <= S_IDLE;
      miso_o     <= 1'b0;
      busy_o     <= 1'b0;
      cmd_cnt_o  <= '0;
      bit_cnt    <= '0;
      addr_cnt   <= '0;
      dummy_cnt  <= '0;
      id_idx     <= '0;
      is_fast    <= 1'b0;
      recognised <= 1'b0;
      rx_sh      <= '0;
      tx_sh      <= '0;
      ptr        <= '0;
    end else if (cs_s) begin
      state      <= S_IDLE;
      miso_o     <= 1'b1;
      busy_o     <= 1'b0;
      bit_cnt    <= '0;
      recognised <= 1'b0;
      if (recognised) cmd_cnt_o <= cmd_cnt_o + 1'b1;
    end else if (state == S_IDLE) begin
      // Only a genuine high-to-low CS transition starts decoding.
      if (cs_fall) begin
        state   <= S_CMD;
        busy_o  <= 1'b1;
        miso_o  <= 1'b0;
        bit_cnt <= '0;
        rx_sh   <= '0;
        tx_sh   <= '0;
      end
    end else begin
      if (sck_rise) begin
        rx_sh   <= rx_byte[6:0];
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (sck_fall) begin
        miso_o <= tx_sh[7];
        tx_sh  <= {tx_sh[6:0], 1'b0};
      end
      // A byte-complete load overrides the shift; rise and fall never coincide.
      if (byte_done) begin
        unique case (state)
          S_CMD: begin
            unique case (rx_byte)
              OP_READ, OP_FAST_READ: begin
                state      <= S_ADDR;
                is_fast    <= (rx_byte == OP_FAST_READ);
                addr_cnt   <= '0;
                recognised <= 1'b1;
              end
              OP_RDID: begin
                state      <= S_ID;
                tx_sh      <= JEDEC_ID[23:16];
                id_idx     <= 2'd1;
                recognised <= 1'b1;
              end
              OP_RDSR: begin
                state      <= S_STATUS;
                recognised <= 1'b1;
              end
              default: state <= S_IGNORE;
            endcase
          end
          S_ADDR: begin
            ptr      <= ptr_shift;
            addr_cnt <= addr_cnt + 1'b1;
            if (addr_cnt == 3'(ADDR_BYTES - 1)) begin
              if (!is_fast || DUMMY_BYTES == 0) begin
                state <= S_DATA;
                tx_sh <= mem[ptr_shift];
                ptr   <= ptr_shift + 1'b1;
              end else begin
                state     <= S_DUMMY;
                dummy_cnt <= '0;
              end
            end
          end
          S_DUMMY: begin
            dummy_cnt <= dummy_cnt + 1'b1;
            if (dummy_cnt == 3'(DUMMY_BYTES - 1)) begin
              state <= S_DATA;
              tx_sh <= mem[ptr];
              ptr   <= ptr + 1'b1;
            end
          end
          S_DATA: begin
            tx_sh <= mem[ptr];
            ptr   <= ptr + 1'b1;
          end
          S_ID: begin
            unique case (id_idx)
              2'd1:    tx_sh <= JEDEC_ID[15:8];
              2'd2:    tx_sh <= JEDEC_ID[7:0];
              default: tx_sh <= 8'h00;
            endcase
            if (id_idx != 2'd3) id_idx <= id_idx + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_model.sv
// Directed bench for spi_flash_model: drives mode-0 SPI transactions as the bus master
// and compares the returned bytes and status outputs against hand-computed values.
module tb_spi_flash_model;

  localparam int HP = 6;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        flash_CS;
  logic        sck_i;
  logic        mosi_i;
  logic        miso_o;
  logic        bd_we_i;
  logic [11:0] bd_addr_i;
  logic [7:0]  bd_data_i;
  logic        busy_o;
  logic [15:0] cmd_cnt_o;

  int tests = 0;
  int fails = 0;

  spi_flash_model #(
    .ADDR_BYTES(3), .MEM_AW(12), .DUMMY_BYTES(1), .JEDEC_ID(24'hEF4016), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_i(rst_i), .flash_CS(flash_CS), .sck_i(sck_i), .mosi_i(mosi_i),
    .miso_o(miso_o), .bd_we_i(bd_we_i), .bd_addr_i(bd_addr_i), .bd_data_i(bd_data_i),
    .busy_o(busy_o), .cmd_cnt_o(cmd_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_we_i = 1'b1; bd_addr_i = a; bd_data_i = d;
    @(negedge clk);
    bd_we_i = 1'b0;
  endtask

  // One byte, MSB first; MISO is sampled just before each rising SCK.
  task automatic xfer(input logic [7:0] d, output logic [7:0] r);
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      mosi_i = d[i];
      repeat (HP) @(negedge clk);
      r[i] = miso_o;
      sck_i = 1'b1;
      repeat (HP) @(negedge clk);
      sck_i = 1'b0;
    end
  endtask

  task automatic cs_low();
    repeat (4) @(negedge clk);
    flash_CS = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HP) @(negedge clk);
    flash_CS = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  logic [7:0] r;

  initial begin
    rst_i = 1'b1; flash_CS = 1'b1; sck_i = 1'b0; mosi_i = 1'b0;
    bd_we_i = 1'b0; bd_addr_i = '0; bd_data_i = '0;

    // Backdoor preload while reset is held.
    bd_write(12'h010, 8'hA5);
    bd_write(12'h011, 8'h5A);
    bd_write(12'h012, 8'hC3);
    bd_write(12'h013, 8'h3C);
    bd_write(12'hFFF, 8'h77);
    bd_write(12'h000, 8'h88);
    @(negedge clk); rst_i = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_miso", 32'(miso_o), 32'h1);
    check("idle_busy", 32'(busy_o), 32'h0);
    check("idle_cnt", 32'(cmd_cnt_o), 32'h0);

    // READ 0x000010, four bytes.
    cs_low();
    check("read_busy", 32'(busy_o), 32'h1);
    xfer(8'h03, r); xfer(8'h00, r); xfer(8'h00, r); xfer(8'h10, r);
    xfer(8'h00, r); check("read_b0", 32'(r), 32'hA5);
    xfer(8'h00, r); check("read_b1", 32'(r), 32'h5A);
    xfer(8'h00, r); check("read_b2", 32'(r), 32'hC3);
    xfer(8'h00, r); check("read_b3", 32'(r), 32'h3C);
    cs_high();
    check("read_end_busy", 32'(busy_o), 32'h0);
    check("read_end_miso", 32'(miso_o), 32'h1);
    check("read_cnt", 32'(cmd_cnt_o), 32'h1);

    // FAST_READ 0x000FFF with one dummy byte; pointer wraps to 0x000.
    cs_low();
    xfer(8'h0B, r); xfer(8'h00, r); xfer(8'h0F, r); xfer(8'hFF, r);
    xfer(8'h00, r); check("fast_dummy", 32'(r), 32'h00);
    xfer(8'h00, r); check("fast_b0", 32'(r), 32'h77);
    xfer(8'h00, r); check("fast_wrap", 32'(r), 32'h88);
    cs_high();
    check("fast_cnt", 32'(cmd_cnt_o), 32'h2);

    // RDID then a trailing zero byte.
    cs_low();
    xfer(8'h9F, r);
    xfer(8'h00, r); check("id_b0", 32'(r), 32'hEF);
    xfer(8'h00, r); check("id_b1", 32'(r), 32'h40);
    xfer(8'h00, r); check("id_b2", 32'(r), 32'h16);
    xfer(8'h00, r); check("id_b3", 32'(r), 32'h00);
    cs_high();
    check("id_cnt", 32'(cmd_cnt_o), 32'h3);

    // Unknown opcode: zeros, not counted.
    cs_low();
    xfer(8'hAB, r);
    xfer(8'hFF, r); check("ign_b0", 32'(r), 32'h00);
    xfer(8'hFF, r); check("ign_b1", 32'(r), 32'h00);
    cs_high();
    check("ign_cnt", 32'(cmd_cnt_o), 32'h3);

    // READ aborted after two address bytes; still a recognised command.
    cs_low();
    xfer(8'h03, r); xfer(8'h00, r); xfer(8'h00, r);
    cs_high();
    check("abort_busy", 32'(busy_o), 32'h0);
    check("abort_cnt", 32'(cmd_cnt_o), 32'h4);
    cs_low();
    xfer(8'h03, r); xfer(8'h00, r); xfer(8'h00, r); xfer(8'h10, r);
    xfer(8'h00, r); check("reread_b0", 32'(r), 32'hA5);
    xfer(8'h00, r); check("reread_b1", 32'(r), 32'h5A);
    cs_high();
    check("reread_cnt", 32'(cmd_cnt_o), 32'h5);

    // One-cycle reset during DATA with CS held low.
    cs_low();
    xfer(8'h03, r); xfer(8'h00, r); xfer(8'h00, r); xfer(8'h10, r);
    xfer(8'h00, r); check("rst_pre_b0", 32'(r), 32'hA5);
    @(negedge clk); rst_i = 1'b1;
    @(negedge clk); rst_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(miso_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_cnt", 32'(cmd_cnt_o), 32'h0);
    xfer(8'h03, r); check("rst_ignored", 32'(r), 32'h00);
    check("rst_still_idle", 32'(busy_o), 32'h0);
    cs_high();
    check("rst_cs_high_miso", 32'(miso_o), 32'h1);
    cs_low();
    xfer(8'h03, r); xfer(8'h00, r); xfer(8'h00, r); xfer(8'h11, r);
    xfer(8'h00, r); check("post_rst_b0", 32'(r), 32'h5A);
    cs_high();
    check("post_rst_cnt", 32'(cmd_cnt_o), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
